wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter_if.sv | 37 +++
 rtl/wb_arbiter.sv | 89 ++++++++
 tb/tb_wb_arbiter.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: per-requester result inputs, one-hot accept, and the
// shared scoreboard writeback port. The exception type lives in the package so
// the arbiter and its users agree on one layout.
package wb_arbiter_pkg;
  typedef struct packed {
    logic        valid;
    logic [63:0] cause;
    logic [63:0] tval;
  } exception_t;
endpackage

interface wb_arbiter_if #(
  parameter int unsigned NR_REQ        = 4,
  parameter int unsigned TRANS_ID_BITS = 3
) ();
  logic [NR_REQ-1:0]                         valid_i;
  logic [NR_REQ-1:0]                         ready_o;
  logic [NR_REQ-1:0][TRANS_ID_BITS-1:0]      trans_id_i;
  logic [NR_REQ-1:0][63:0]                   wbdata_i;
  wb_arbiter_pkg::exception_t [NR_REQ-1:0]   ex_i;
  logic                                      wt_valid_o;
  logic [TRANS_ID_BITS-1:0]                  trans_id_o;
  logic [63:0]                               wbdata_o;
  wb_arbiter_pkg::exception_t                ex_o;

  // Arbiter side
  modport slave (
    input  valid_i, trans_id_i, wbdata_i, ex_i,
    output ready_o, wt_valid_o, trans_id_o, wbdata_o, ex_o
  );

  // Requester / scoreboard side
  modport master (
    output valid_i, trans_id_i, wbdata_i, ex_i,
    input  ready_o, wt_valid_o, trans_id_o, wbdata_o, ex_o
  );
endinterface

// File: rtl/wb_arbiter.sv
// Round-robin writeback arbiter: grants one functional-unit result per cycle
// and registers it onto the scoreboard writeback port (latency 1).
// Optional macro WB_ARB_EXC_PRIO_EN: requesters flagging an exception win
// over non-exception requesters (round-robin among them from the pointer).
module wb_arbiter #(
  parameter int unsigned NR_REQ        = 4,
  parameter int unsigned TRANS_ID_BITS = 3
) (
  input logic         clk_i,
  input logic         rst_i,
  input logic         flush_i,
  wb_arbiter_if.slave bus
);
  localparam int unsigned PTR_W = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;

  logic [PTR_W-1:0]           r_ptr;
  logic                       r_wt_valid;
  logic [TRANS_ID_BITS-1:0]   r_trans_id;
  logic [63:0]                r_wbdata;
  wb_arbiter_pkg::exception_t r_ex;

  logic [NR_REQ-1:0] w_cand;
  logic [NR_REQ-1:0] w_grant;
  logic [PTR_W-1:0]  w_sel;
  logic [PTR_W-1:0]  w_idx;
  logic [PTR_W:0]    w_sum;
  logic [PTR_W-1:0]  w_ptr_nxt;
  logic              w_found;
  logic              w_xfer;
`ifdef WB_ARB_EXC_PRIO_EN
  logic [NR_REQ-1:0] w_exc;
`endif

  // Pick the first candidate at or after the pointer, wrapping modulo NR_REQ
  always_comb begin
    w_cand = bus.valid_i;
`ifdef WB_ARB_EXC_PRIO_EN
    w_exc = '0;
    for (int unsigned k = 0; k < NR_REQ; k++) begin
      w_exc[k] = bus.valid_i[k] & bus.ex_i[k].valid;
    end
    if (|w_exc) w_cand = w_exc;
`endif
    w_grant = '0;
    w_sel   = '0;
    w_found = 1'b0;
    w_sum   = '0;
    w_idx   = '0;
    for (int unsigned k = 0; k < NR_REQ; k++) begin
      // ptr + k < 2*NR_REQ, so a single conditional subtract is an exact modulo
      w_sum = {1'b0, r_ptr} + (PTR_W+1)'(k);
      if (w_sum >= (PTR_W+1)'(NR_REQ)) w_sum = w_sum - (PTR_W+1)'(NR_REQ);
      w_idx = w_sum[PTR_W-1:0];
      if (!w_found && w_cand[w_idx]) begin
        w_found = 1'b1;
        w_sel   = w_idx;
      end
    end
    if (w_found && !flush_i && !rst_i) w_grant[w_sel] = 1'b1;
    w_ptr_nxt = (w_sel == PTR_W'(NR_REQ-1)) ? '0 : w_sel + 1'b1;
  end

  assign w_xfer = |w_grant;

  // Capture the granted payload and advance the pointer past the winner
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ptr      <= '0;
      r_wt_valid <= 1'b0;
      r_trans_id <= '0;
      r_wbdata   <= '0;
      r_ex       <= '0;
    end else begin
      r_wt_valid <= w_xfer;
      if (w_xfer) begin
        r_ptr      <= w_ptr_nxt;
        r_trans_id <= bus.trans_id_i[w_sel];
        r_wbdata   <= bus.wbdata_i[w_sel];
        r_ex       <= bus.ex_i[w_sel];
      end
    end
  end

  assign bus.ready_o    = w_grant;
  assign bus.wt_valid_o = r_wt_valid;
  assign bus.trans_id_o = r_trans_id;
  assign bus.wbdata_o   = r_wbdata;
  assign bus.ex_o       = r_ex;
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter (NR_REQ=4, TRANS_ID_BITS=3).
module tb_wb_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic flush;
  int   checks   = 0;
  int   failures = 0;

  wb_arbiter_if #(.NR_REQ(4), .TRANS_ID_BITS(3)) bus ();

  wb_arbiter #(.NR_REQ(4), .TRANS_ID_BITS(3)) u_dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .flush_i (flush),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [3:0] exp_ready;
    rst   = 1'b1;
    flush = 1'b0;
    bus.valid_i = '0;
    bus.ex_i    = '0;
    for (int i = 0; i < 4; i++) begin
      bus.trans_id_i[i] = 3'(i + 4);
      bus.wbdata_i[i]   = 64'hC0DE_0000_0000_0000 + 64'(i);
    end
    tick();
    tick();

    // Reset held while all requesters are valid
    bus.valid_i = 4'b1111;
    #1;
    chk("rst_ready", 64'(bus.ready_o), 64'h0);
    tick();
    chk("rst_wt_valid", 64'(bus.wt_valid_o), 64'h0);
    chk("rst_trans_id", 64'(bus.trans_id_o), 64'h0);
    chk("rst_wbdata", bus.wbdata_o, 64'h0);
    chk("rst_ex_valid", 64'(bus.ex_o.valid), 64'h0);

    // Release: 8 cycles all-valid -> grants 0,1,2,3,0,1,2,3
    rst = 1'b0;
    #1;
    for (int c = 0; c < 8; c++) begin
      exp_ready = 4'b0001 << (c % 4);
      chk("rr_ready", 64'(bus.ready_o), 64'(exp_ready));
      if (c > 0) begin
        chk("rr_wt_valid", 64'(bus.wt_valid_o), 64'h1);
        chk("rr_trans_id", 64'(bus.trans_id_o), 64'(4 + ((c - 1) % 4)));
      end
      tick();
    end
    chk("rr_last_wt_valid", 64'(bus.wt_valid_o), 64'h1);
    chk("rr_last_trans_id", 64'(bus.trans_id_o), 64'h7);
    chk("rr_last_wbdata", bus.wbdata_o, 64'hC0DE_0000_0000_0003);
    bus.valid_i = 4'b0000;
    #1;
    chk("idle_ready", 64'(bus.ready_o), 64'h0);
    tick();
    chk("idle_wt_valid", 64'(bus.wt_valid_o), 64'h0);
    chk("idle_hold_trans_id", 64'(bus.trans_id_o), 64'h7);
    chk("idle_hold_wbdata", bus.wbdata_o, 64'hC0DE_0000_0000_0003);

    // Pointer 0 -> grant 0, grant 1, pointer now 2
    bus.valid_i = 4'b0011;
    #1;
    chk("p0_ready", 64'(bus.ready_o), 64'h1);
    tick();
    chk("p1_ready", 64'(bus.ready_o), 64'h2);
    tick();
    // Pointer 2 with only 0,1 valid -> wraps to requester 0
    chk("wrap_ready", 64'(bus.ready_o), 64'h1);
    tick();
    chk("wrap_trans_id", 64'(bus.trans_id_o), 64'h4);
    chk("after_wrap_ptr1", 64'(bus.ready_o), 64'h2);
    tick();

    // Pointer 2: flush blocks grant and pointer holds
    bus.valid_i = 4'b0110;
    flush = 1'b1;
    #1;
    chk("flush_ready", 64'(bus.ready_o), 64'h0);
    tick();
    chk("flush_wt_valid", 64'(bus.wt_valid_o), 64'h0);
    flush = 1'b0;
    #1;
    chk("post_flush_ready", 64'(bus.ready_o), 64'h4);
    tick();
    chk("post_flush_wt_valid", 64'(bus.wt_valid_o), 64'h1);
    chk("post_flush_trans_id", 64'(bus.trans_id_o), 64'h6);

    // Valid drops without transfer
    bus.valid_i = 4'b0000;
    tick();
    chk("drop_wt_valid", 64'(bus.wt_valid_o), 64'h0);

    // Single requester after reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.valid_i = 4'b0001;
    bus.trans_id_i[0] = 3'd3;
    bus.wbdata_i[0]   = 64'hDEAD;
    #1;
    chk("single_ready", 64'(bus.ready_o), 64'h1);
    tick();
    chk("single_wt_valid", 64'(bus.wt_valid_o), 64'h1);
    chk("single_trans_id", 64'(bus.trans_id_o), 64'h3);
    chk("single_wbdata", bus.wbdata_o, 64'hDEAD);
    bus.valid_i = 4'b0000;
    tick();
    chk("single_one_cycle", 64'(bus.wt_valid_o), 64'h0);

    // Exception requester vs pointer 0
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.valid_i = 4'b1001;
    bus.ex_i[3].valid = 1'b1;
    bus.ex_i[3].cause = 64'h2;
    #1;
`ifdef WB_ARB_EXC_PRIO_EN
    chk("exc_ready", 64'(bus.ready_o), 64'h8);
    tick();
    chk("exc_ex_valid", 64'(bus.ex_o.valid), 64'h1);
    chk("exc_trans_id", 64'(bus.trans_id_o), 64'h7);
`else
    chk("exc_ready", 64'(bus.ready_o), 64'h1);
    tick();
    chk("exc_ex_valid", 64'(bus.ex_o.valid), 64'h0);
    chk("exc_trans_id", 64'(bus.trans_id_o), 64'h3);
`endif
    chk("exc_wt_valid", 64'(bus.wt_valid_o), 64'h1);
    bus.valid_i = 4'b0000;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
